pre_spike_cnt_drain: RTL and testbench

- Read-out and clear engine for the pre-synaptic spike-count SRAM.
- Runs once the per-neuron update path has accumulated counts for a time-reference window.
- On a scan request it walks every pre-neuron address, reads the stored 8-bit count, and hands each (address, count) pair to the forward-forward weight-update logic over a valid/ready stream.
- After each accepted transfer it writes zero back, so the next window starts from a cleared count.

---
 rtl/pre_spike_cnt_drain.sv | 189 ++++++++++++++++++
 tb/tb_pre_spike_cnt_drain.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pre_spike_cnt_drain.sv
// pre_spike_cnt_drain
// Read-out and clear engine for the pre-synaptic spike-count SRAM.
//
// On a scan request the engine walks every pre-neuron address in order:
//   RD   : issue an SRAM read at the current address
//   WAIT : capture the read data into the count register
//   OUT  : present (address, count) on a valid/ready stream
//   CLR  : write zero back to the same address, then advance
//   DONE : one-cycle scan_done pulse, then back to IDLE
//
// Optional build macro: PRE_DRAIN_SKIP_ZERO_EN
//   When defined, an entry that reads back as zero is not streamed and not
//   rewritten. The engine moves straight on to the next address, so a zero
//   entry costs 2 cycles instead of 4.
//
// Every output is taken straight from a register. sram_addr is the address
// register itself, and sram_wdata is the constant zero.

module pre_spike_cnt_drain #(
    parameter int N_PRE  = 256,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              scan_start,
    output logic              scan_busy,
    output logic              scan_done,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [CNT_W-1:0]  sram_wdata,
    input  logic [CNT_W-1:0]  sram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [CNT_W-1:0]  out_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_OUT  = 3'd3,
        ST_CLR  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // The scan stops at N_PRE-1 even when the address space is larger.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PRE - 1);

    state_t              state_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [ADDR_W-1:0]   out_addr_r;
    logic                busy_r;
    logic                done_r;
    logic                cs_r;
    logic                we_r;
    logic                valid_r;

    logic [ADDR_W-1:0]   addr_inc_s;
    logic                last_s;

    assign addr_inc_s = addr_r + ADDR_W'(1);
    assign last_s     = (addr_r == LAST_ADDR);

    assign scan_busy  = busy_r;
    assign scan_done  = done_r;
    assign sram_cs    = cs_r;
    assign sram_we    = we_r;
    assign sram_addr  = addr_r;
    assign sram_wdata = CNT_W'(0);
    assign out_valid  = valid_r;
    assign out_addr   = out_addr_r;
    assign out_cnt    = cnt_r;

    // Scan sequencer. Each registered output is loaded with the value it
    // must carry in the state being entered.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r    <= ST_IDLE;
            addr_r     <= '0;
            cnt_r      <= '0;
            out_addr_r <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            cs_r       <= 1'b0;
            we_r       <= 1'b0;
            valid_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r  <= 1'b0;
                    we_r    <= 1'b0;
                    valid_r <= 1'b0;
                    if (scan_start) begin
                        state_r <= ST_RD;
                        addr_r  <= '0;
                        busy_r  <= 1'b1;
                        cs_r    <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                        cs_r    <= 1'b0;
                    end
                end

                ST_RD: begin
                    // The read was issued in this cycle; data arrives next cycle.
                    state_r <= ST_WAIT;
                    cs_r    <= 1'b0;
                    we_r    <= 1'b0;
                end

                ST_WAIT: begin
                    cnt_r <= sram_rdata;
`ifdef PRE_DRAIN_SKIP_ZERO_EN
                    if (sram_rdata == CNT_W'(0)) begin
                        // A zero entry is already clear: skip the transfer and the write-back.
                        if (last_s) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            cs_r    <= 1'b0;
                        end else begin
                            state_r <= ST_RD;
                            addr_r  <= addr_inc_s;
                            cs_r    <= 1'b1;
                        end
                        we_r <= 1'b0;
                    end else begin
                        state_r    <= ST_OUT;
                        out_addr_r <= addr_r;
                        valid_r    <= 1'b1;
                    end
`else
                    state_r    <= ST_OUT;
                    out_addr_r <= addr_r;
                    valid_r    <= 1'b1;
`endif
                end

                ST_OUT: begin
                    // Valid and payload stay frozen until the consumer takes the transfer.
                    if (out_ready) begin
                        state_r <= ST_CLR;
                        valid_r <= 1'b0;
                        cs_r    <= 1'b1;
                        we_r    <= 1'b1;
                    end else begin
                        state_r <= ST_OUT;
                        valid_r <= 1'b1;
                    end
                end

                ST_CLR: begin
                    we_r <= 1'b0;
                    if (last_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        cs_r    <= 1'b0;
                    end else begin
                        state_r <= ST_RD;
                        addr_r  <= addr_inc_s;
                        cs_r    <= 1'b1;
                    end
                end

                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    cs_r    <= 1'b0;
                    we_r    <= 1'b0;
                    valid_r <= 1'b0;
                end

                default: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    cs_r    <= 1'b0;
                    we_r    <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pre_spike_cnt_drain.sv
// Testbench for pre_spike_cnt_drain.
// The SRAM is modelled with a one-cycle read latency. Random read data is
// driven whenever no read result is due, so a capture on the wrong cycle is
// detected. Expected transfers, scan length and final SRAM contents come from
// a reference model that works on the SRAM snapshot taken at scan start.
module tb_pre_spike_cnt_drain;
    localparam int N_PRE  = 256;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 8;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              scan_start = 1'b0;
    logic              out_ready = 1'b0;
    logic [CNT_W-1:0]  sram_rdata = 8'h00;
    logic              scan_busy, scan_done, sram_cs, sram_we, out_valid;
    logic [ADDR_W-1:0] sram_addr, out_addr;
    logic [CNT_W-1:0]  sram_wdata, out_cnt;

    always #5 CLK = ~CLK;

    pre_spike_cnt_drain #(.N_PRE(N_PRE), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .scan_start(scan_start), .scan_busy(scan_busy),
        .scan_done(scan_done), .sram_cs(sram_cs), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_cnt(out_cnt)
    );

    typedef struct {int a; int c;} xfer_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mem  [N_PRE];
    logic [7:0]  snap [N_PRE];
    logic [7:0]  ref4 [N_PRE];
    xfer_t       got[$];
    xfer_t       exp_q[$];
    bit          pend_v = 1'b0;
    logic [7:0]  pend_d = 8'h00;
    bit          hs_open = 1'b0;
    int          hs_addr = 0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_addr = 8'h00;
    logic [7:0]  prev_cnt = 8'h00;
    int          last_stalls = 0;

    function automatic bit skip_on();
`ifdef PRE_DRAIN_SKIP_ZERO_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk(tag, {scan_busy, scan_done, sram_cs, sram_we, sram_addr, sram_wdata,
                  out_valid, out_addr, out_cnt}, 64'd0);
    endtask

    // Advance to the next falling edge and model the SRAM plus bus rules.
    task automatic cycle();
        @(negedge CLK);
        if (pend_v) sram_rdata = pend_d;
        else        sram_rdata = 8'($urandom);
        pend_v = 1'b0;
        chk("we_without_cs", {31'd0, sram_we & ~sram_cs}, 64'd0);
        if (sram_cs && !sram_we) begin
            pend_v = 1'b1;
            pend_d = mem[sram_addr];
        end
        if (sram_cs && sram_we) begin
            chk("wdata_zero", sram_wdata, 64'd0);
            chk("clr_after_hs", {hs_open, sram_addr}, {1'b1, hs_addr[7:0]});
            hs_open = 1'b0;
            mem[sram_addr] = sram_wdata;
        end
        if (prev_stall)
            chk("hold_while_stalled", {out_valid, out_addr, out_cnt}, {1'b1, prev_addr, prev_cnt});
    endtask

    // mode 0: ready always high, 1: random ready, 2: ready low 5 cycles at addr 3.
    task automatic run_scan(input int mode, input int restart_at, input int abort_at,
                            output bit aborted);
        int c;
        int stalls;
        int st;
        int exp_cycles;
        int nz;
        bit st_done;
        bit restarted;
        aborted = 1'b0;
        snap = mem;
        got.delete();
        exp_q.delete();
        exp_cycles = 1;
        for (int i = 0; i < N_PRE; i++) begin
            if (skip_on() && snap[i] == 8'h00) begin
                exp_cycles += 2;
            end else begin
                exp_cycles += 4;
                exp_q.push_back('{i, int'(snap[i])});
            end
        end
        cycle();
        scan_start = 1'b1;
        out_ready  = 1'b1;
        c = 0; stalls = 0; st = 0; st_done = 1'b0; restarted = 1'b0;
        prev_stall = 1'b0;
        while (1) begin
            cycle();
            c++;
            scan_start = 1'b0;
            chk("busy_during_scan", {31'd0, scan_busy}, 64'd1);
            if (scan_done) break;
            if (c > 6000) begin
                chk("scan_timeout", 64'd0, 64'd1);
                break;
            end
            if (restart_at >= 0 && !restarted && out_valid && out_addr == restart_at[7:0]) begin
                scan_start = 1'b1;
                restarted  = 1'b1;
            end
            if (abort_at >= 0 && out_valid && out_addr == abort_at[7:0]) begin
                out_ready = 1'b0;
                prev_stall = 1'b0;
                aborted = 1'b1;
                return;
            end
            if (mode == 2 && !st_done && out_valid && out_addr == 8'd3) begin
                st = 5;
                st_done = 1'b1;
            end
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    out_ready = (st > 0) ? 1'b0 : 1'b1;
                    if (st > 0) st--;
                end
            endcase
            prev_stall = out_valid && !out_ready;
            prev_addr  = out_addr;
            prev_cnt   = out_cnt;
            if (prev_stall) stalls++;
            if (out_valid && out_ready) begin
                chk("hs_before_clear", {31'd0, hs_open}, 64'd0);
                got.push_back('{int'(out_addr), int'(out_cnt)});
                hs_open = 1'b1;
                hs_addr = int'(out_addr);
            end
        end
        prev_stall = 1'b0;
        last_stalls = stalls;
        chk("scan_length", c, exp_cycles + stalls);
        chk("xfer_count", got.size(), exp_q.size());
        for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
            chk("xfer_addr", got[k].a, exp_q[k].a);
            chk("xfer_cnt", got[k].c, exp_q[k].c);
        end
        nz = 0;
        for (int i = 0; i < N_PRE; i++) if (mem[i] != 8'h00) nz++;
        chk("sram_cleared", nz, 0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("done_single_pulse", {31'd0, scan_done}, 64'd0);
            chk("idle_not_busy", {31'd0, scan_busy}, 64'd0);
        end
    endtask

    initial begin
        bit ab;
        int bad;
        for (int i = 0; i < N_PRE; i++) mem[i] = 8'h00;
        repeat (3) cycle();
        chk_outputs_zero("reset_outputs");
        RST_N = 1'b1;
        cycle();
        chk_outputs_zero("idle_outputs");

        // Incrementing pattern, ready always high.
        for (int i = 0; i < N_PRE; i++) mem[i] = 8'(i + 1);
        run_scan(0, -1, -1, ab);

        // Consumer stalls 5 cycles at address 3.
        for (int i = 0; i < N_PRE; i++) mem[i] = 8'($urandom);
        mem[3] = 8'h04;
        run_scan(2, -1, -1, ab);
        chk("stall_cycles", last_stalls, 5);

        // Second scan_start while busy is dropped.
        for (int i = 0; i < N_PRE; i++) mem[i] = 8'($urandom);
        run_scan(0, 10, -1, ab);

        // Reset in the middle of the scan at address 100.
        for (int i = 0; i < N_PRE; i++) mem[i] = 8'($urandom_range(1, 255));
        ref4 = mem;
        run_scan(0, -1, 100, ab);
        chk("abort_reached", {31'd0, ab}, 64'd1);
        RST_N = 1'b0;
        #1;
        chk_outputs_zero("async_reset_outputs");
        cycle();
        chk_outputs_zero("reset_hold_outputs");
        RST_N = 1'b1;
        pend_v = 1'b0;
        hs_open = 1'b0;
        cycle();
        chk_outputs_zero("after_reset_idle");
        bad = 0;
        for (int i = 0; i < N_PRE; i++) begin
            if (i < 100 && mem[i] != 8'h00) bad++;
            if (i >= 100 && mem[i] != ref4[i]) bad++;
        end
        chk("partial_clear", bad, 0);
        run_scan(1, -1, -1, ab);

        // Sparse contents: only two non-zero entries.
        for (int i = 0; i < N_PRE; i++) mem[i] = 8'h00;
        mem[7] = 8'h55;
        mem[255] = 8'hFF;
        run_scan(0, -1, -1, ab);

        // Maximum count at address 0, random back-pressure.
        for (int i = 0; i < N_PRE; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hFF;
        run_scan(1, -1, -1, ab);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
